// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall unit: FSM encodings, register
// index defaults and the bit layout of one tracker stage tag.
package hazard_pkg;

    localparam int REG_W_DEF = 5;

    // Register 0 is hard-wired to zero, so it never creates a dependency
    localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2,
        ST_STEP     = 2'd3
    } hz_state_t;

    // Stage tag layout: {valid, wr, ld, rw[REG_W-1:0]}
    // Flag offsets are counted upward from the bit just above rw
    localparam int TAG_FLAG_W    = 3;
    localparam int TAG_LD_OFS    = 0;
    localparam int TAG_WR_OFS    = 1;
    localparam int TAG_VALID_OFS = 2;

endpackage

// File: rtl/hazard_stall_unit_stage_tag_reg.sv
// One stage of the in-flight writer tracker: loads the previous stage's tag,
// optionally loads an all-zero bubble instead, or holds.
import hazard_pkg::*;

module stage_tag_reg #(
    parameter int TAG_W = REG_W_DEF + TAG_FLAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [TAG_W-1:0] d,
    output logic [TAG_W-1:0] q
);

    // Tag register: a cleared load inserts an empty (invalid) slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= clear ? '0 : d;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard and stall controller for the 5-stage core: tracks the
// destination tags of in-flight writers, detects load-use hazards, freezes
// the pipe while data memory is busy and services debug halt/step/resume.
import hazard_pkg::*;

module hazard_stall_unit #(
    parameter int REG_W       = REG_W_DEF,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs_ID,
    input  logic [REG_W-1:0] rt_ID,
    input  logic             uses_rs,
    input  logic             uses_rt,
    input  logic [REG_W-1:0] rw_ID,
    input  logic             reg_write_ID,
    input  logic             mem_read_ID,
    input  logic             mem_busy,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             resume_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             pipe_en,
    output logic [REG_W-1:0] rw_EX_MEM,
    output logic [REG_W-1:0] rw_MEM_WB,
    output logic             write_reg_EX_MEM,
    output logic             write_reg_MEM_WB,
    output logic             mem_read_EX_MEM,
    output logic             halted,
    output logic             mem_timeout
);

    localparam int TAG_W = REG_W + TAG_FLAG_W;
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [REG_W-1:0] ZERO_TAG  = REG_W'(ZERO_REG);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MEM_TIMEOUT - 1);

    hz_state_t state, next_state;
    hz_state_t ret_state, next_ret;

    logic [CNT_W-1:0] wait_cnt;
    logic             set_timeout;
    logic             clr_timeout;
    logic             load_use;

    logic [TAG_W-1:0] tag_id, tag_ex, tag_mem, tag_wb;
    logic [REG_W-1:0] ex_rw;
    logic             ex_valid, ex_ld;
    logic             wb_ld_unused;

    // The ID instruction always occupies a valid slot when it enters EX
    assign tag_id = {1'b1, reg_write_ID, mem_read_ID, rw_ID};

    stage_tag_reg #(.TAG_W(TAG_W)) u_stage_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pipe_en),
        .clear (id_ex_bubble),
        .d     (tag_id),
        .q     (tag_ex)
    );

    stage_tag_reg #(.TAG_W(TAG_W)) u_stage_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pipe_en),
        .clear (1'b0),
        .d     (tag_ex),
        .q     (tag_mem)
    );

    stage_tag_reg #(.TAG_W(TAG_W)) u_stage_wb (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pipe_en),
        .clear (1'b0),
        .d     (tag_mem),
        .q     (tag_wb)
    );

    assign ex_rw    = tag_ex[REG_W-1:0];
    assign ex_valid = tag_ex[REG_W + TAG_VALID_OFS];
    assign ex_ld    = tag_ex[REG_W + TAG_LD_OFS];

    // The load flag of the WB slot has no consumer
    assign wb_ld_unused = tag_wb[REG_W + TAG_LD_OFS];

    assign load_use = ex_valid & ex_ld & (ex_rw != ZERO_TAG)
                    & ((uses_rs & (rs_ID == ex_rw)) | (uses_rt & (rt_ID == ex_rw)));

    assign rw_EX_MEM        = tag_mem[REG_W-1:0];
    assign write_reg_EX_MEM = tag_mem[REG_W + TAG_VALID_OFS] & tag_mem[REG_W + TAG_WR_OFS]
                            & (tag_mem[REG_W-1:0] != ZERO_TAG);
    assign mem_read_EX_MEM  = tag_mem[REG_W + TAG_VALID_OFS] & tag_mem[REG_W + TAG_LD_OFS];
    assign rw_MEM_WB        = tag_wb[REG_W-1:0];
    assign write_reg_MEM_WB = tag_wb[REG_W + TAG_VALID_OFS] & tag_wb[REG_W + TAG_WR_OFS]
                            & (tag_wb[REG_W-1:0] != ZERO_TAG);
    assign halted           = (state == ST_HALTED);

    // Next-state and pipeline enables. A halt request still lets the current
    // cycle advance, and a pending load-use hazard still gets its bubble in
    // that cycle so the dependent instruction is never issued with stale data.
    always_comb begin
        next_state   = state;
        next_ret     = ret_state;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        pipe_en      = 1'b1;
        set_timeout  = 1'b0;
        clr_timeout  = 1'b0;
        case (state)
            ST_RUN, ST_STEP: begin
                if (mem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_en     = 1'b0;
                    next_state  = ST_MEM_WAIT;
                    next_ret    = (state == ST_STEP) ? ST_HALTED : ST_RUN;
                end else begin
                    if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                    if ((state == ST_STEP) || halt_req) begin
                        next_state = ST_HALTED;
                    end
                end
            end
            ST_MEM_WAIT: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_en     = 1'b0;
                if (!mem_busy) begin
                    next_state = ret_state;
                end else if (wait_cnt == CNT_LAST) begin
                    set_timeout = 1'b1;
                    next_state  = ST_HALTED;
                end
            end
            ST_HALTED: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_en     = 1'b0;
                if (step_req) begin
                    next_state = ST_STEP;
                end else if (resume_req) begin
                    clr_timeout = 1'b1;
                    next_state  = ST_RUN;
                end
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase
    end

    // FSM state and the state to return to once a memory wait ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
        end else begin
            state     <= next_state;
            ret_state <= next_ret;
        end
    end

    // Memory wait counter (cleared whenever the wait ends) and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if ((state == ST_MEM_WAIT) && (next_state == ST_MEM_WAIT)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (set_timeout) begin
                mem_timeout <= 1'b1;
            end else if (clr_timeout) begin
                mem_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized self-checking bench for hazard_stall_unit against a behavioural
// model of the pipeline occupancy and debug/memory-wait modes.
module tb_hazard_stall_unit;

    localparam int REG_W       = 5;
    localparam int MEM_TIMEOUT = 4;
    localparam int NUM_CYCLES  = 2500;

    localparam int M_RUN    = 0;
    localparam int M_WAIT   = 1;
    localparam int M_HALTED = 2;
    localparam int M_STEP   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [REG_W-1:0] rs_ID, rt_ID, rw_ID;
    logic             uses_rs, uses_rt, reg_write_ID, mem_read_ID;
    logic             mem_busy, halt_req, step_req, resume_req;
    logic             pc_write, if_id_write, id_ex_bubble, pipe_en;
    logic [REG_W-1:0] rw_EX_MEM, rw_MEM_WB;
    logic             write_reg_EX_MEM, write_reg_MEM_WB, mem_read_EX_MEM;
    logic             halted, mem_timeout;

    hazard_stall_unit #(.REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rs_ID            (rs_ID),
        .rt_ID            (rt_ID),
        .uses_rs          (uses_rs),
        .uses_rt          (uses_rt),
        .rw_ID            (rw_ID),
        .reg_write_ID     (reg_write_ID),
        .mem_read_ID      (mem_read_ID),
        .mem_busy         (mem_busy),
        .halt_req         (halt_req),
        .step_req         (step_req),
        .resume_req       (resume_req),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .id_ex_bubble     (id_ex_bubble),
        .pipe_en          (pipe_en),
        .rw_EX_MEM        (rw_EX_MEM),
        .rw_MEM_WB        (rw_MEM_WB),
        .write_reg_EX_MEM (write_reg_EX_MEM),
        .write_reg_MEM_WB (write_reg_MEM_WB),
        .mem_read_EX_MEM  (mem_read_EX_MEM),
        .halted           (halted),
        .mem_timeout      (mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             v;
        bit [REG_W-1:0] rw;
        bit             wr;
        bit             ld;
    } slot_t;

    // Model: slot 0 = instruction in EX, 1 = MEM, 2 = WB
    slot_t trk [3];
    int    mode_m;
    bit    back_to_halt;
    int    wait_len;
    bit    tmo_m;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int busy_left = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_cnt++;
        if (observed === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit modelHazard();
        bit [REG_W-1:0] r;
        r = trk[0].rw;
        return trk[0].v && trk[0].ld && (r != 0)
            && ((uses_rs && (rs_ID == r)) || (uses_rt && (rt_ID == r)));
    endfunction

    function automatic bit modelAdvancing();
        return ((mode_m == M_RUN) || (mode_m == M_STEP)) && !mem_busy;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) trk[i] = '{default: 0};
        mode_m       = M_RUN;
        back_to_halt = 1'b0;
        wait_len     = 0;
        tmo_m        = 1'b0;
    endtask

    task automatic modelStep();
        bit hz;
        bit adv;
        hz  = modelHazard();
        adv = modelAdvancing();
        if (adv) begin
            trk[2] = trk[1];
            trk[1] = trk[0];
            if (hz) trk[0] = '{default: 0};
            else    trk[0] = '{v: 1'b1, rw: rw_ID, wr: reg_write_ID, ld: mem_read_ID};
        end
        case (mode_m)
            M_RUN: begin
                if (mem_busy) begin
                    mode_m = M_WAIT; back_to_halt = 1'b0; wait_len = 0;
                end else if (halt_req) begin
                    mode_m = M_HALTED;
                end
            end
            M_STEP: begin
                if (mem_busy) begin
                    mode_m = M_WAIT; back_to_halt = 1'b1; wait_len = 0;
                end else begin
                    mode_m = M_HALTED;
                end
            end
            M_WAIT: begin
                wait_len++;
                if (!mem_busy) begin
                    mode_m = back_to_halt ? M_HALTED : M_RUN;
                end else if (wait_len == MEM_TIMEOUT) begin
                    tmo_m  = 1'b1;
                    mode_m = M_HALTED;
                end
            end
            default: begin
                if (step_req) begin
                    mode_m = M_STEP;
                end else if (resume_req) begin
                    mode_m = M_RUN; tmo_m = 1'b0;
                end
            end
        endcase
    endtask

    task automatic checkAll();
        bit hz;
        bit adv;
        hz  = modelHazard();
        adv = modelAdvancing();
        checkOutput("pc_write",         32'(pc_write),         32'(adv && !hz));
        checkOutput("if_id_write",      32'(if_id_write),      32'(adv && !hz));
        checkOutput("id_ex_bubble",     32'(id_ex_bubble),     32'(adv && hz));
        checkOutput("pipe_en",          32'(pipe_en),          32'(adv));
        checkOutput("rw_EX_MEM",        32'(rw_EX_MEM),        32'(trk[1].rw));
        checkOutput("rw_MEM_WB",        32'(rw_MEM_WB),        32'(trk[2].rw));
        checkOutput("write_reg_EX_MEM", 32'(write_reg_EX_MEM), 32'(trk[1].v && trk[1].wr && (trk[1].rw != 0)));
        checkOutput("write_reg_MEM_WB", 32'(write_reg_MEM_WB), 32'(trk[2].v && trk[2].wr && (trk[2].rw != 0)));
        checkOutput("mem_read_EX_MEM",  32'(mem_read_EX_MEM),  32'(trk[1].v && trk[1].ld));
        checkOutput("halted",           32'(halted),           32'(mode_m == M_HALTED));
        checkOutput("mem_timeout",      32'(mem_timeout),      32'(tmo_m));
    endtask

    // Small register range so hazards, register 0 and tag matches are frequent
    task automatic applyStimulus();
        rs_ID        = REG_W'($urandom_range(0, 3));
        rt_ID        = REG_W'($urandom_range(0, 3));
        rw_ID        = REG_W'($urandom_range(0, 3));
        uses_rs      = ($urandom_range(0, 3) != 0);
        uses_rt      = ($urandom_range(0, 1) != 0);
        reg_write_ID = ($urandom_range(0, 3) != 0);
        mem_read_ID  = ($urandom_range(0, 1) != 0);
        if ((busy_left == 0) && ($urandom_range(0, 9) == 0)) begin
            busy_left = $urandom_range(1, 7);
        end
        mem_busy = (busy_left != 0);
        if (busy_left != 0) busy_left--;
        halt_req   = ($urandom_range(0, 15) == 0);
        step_req   = ($urandom_range(0, 5) == 0);
        resume_req = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        applyStimulus();
        mem_busy = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkAll();
        rst_n = 1'b1;
        for (int c = 0; c < NUM_CYCLES; c++) begin
            @(posedge clk);
            modelStep();
            #1;
            applyStimulus();
            @(negedge clk);
            checkAll();
            if ($urandom_range(0, 149) == 0) begin
                mem_busy = 1'b0;
                rst_n    = 1'b0;
                #1;
                modelReset();
                checkAll();
                #1;
                rst_n = 1'b1;
            end
        end
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
